pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the CPU pipeline, successor to the fixed-field ID/EX latch. It carries LANES lanes of DATA_W-bit payload with a per-lane valid bit. It decodes the global stall vector for its own stage index and inserts bubbles, holds or advances accordingly. It adds a flush input, per-lane kill, optional payload clearing on bubbles, and saturating stall/bubble performance counters. One instance is placed between every pair of adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 32: payload bits per lane (operator, operands, write-back address, pc, delay-slot flags packed by the instantiating stage).
- LANES, 1: number of issue lanes, 1..4.
- STALL_W, 6: width of the global stall vector.
- STAGE, 2: index of the upstream stage in the stall vector; STAGE+1 must be < STALL_W (elaboration-time check, fatal if violated).
- RESET_VAL, 0: DATA_W-bit payload value written to every lane on reset, flush, and cleared bubbles.
- CLEAR_ON_BUBBLE, 1: 1 = bubble writes RESET_VAL to the payload; 0 = bubble keeps the payload and drops only the valid bit (low-power mode).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: one clock; reset is synchronous and active-low (rst = 0 resets on the next rising clk edge).
- stall  in  STALL_W  global stall vector; bit k = stage k frozen.
- flush  in  1  exception/redirect flush of this register.
- up_valid  in  LANES  per-lane valid from upstream stage.
- up_data  in  LANES*DATA_W  upstream payload; lane i occupies bits [i*DATA_W +: DATA_W].
- lane_kill  in  LANES  per-lane squash, applied on load (branch-likely nullify, second-lane squash).
- dn_valid  out  LANES  registered per-lane valid to downstream stage.
- dn_data  out  LANES*DATA_W  registered payload.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with stall[STAGE] = 1, saturating.
- bubble_cnt  out  CNT_W  bubbles inserted, saturating.

## Operation
Let s_up = stall[STAGE] and s_dn = stall[STAGE+1]. Register update at each rising clk edge follows this priority; the first matching row wins:
1. rst = 0: dn_valid = 0, every lane of dn_data = RESET_VAL, stall_cnt = 0, bubble_cnt = 0.
2. flush = 1: dn_valid = 0, dn_data = RESET_VAL in all lanes, regardless of stall.
3. Bubble (s_up = 1, s_dn = 0): dn_valid = 0. dn_data = RESET_VAL if CLEAR_ON_BUBBLE = 1, otherwise held.
4. Advance (s_up = 0): dn_data[i] = up_data[i] and dn_valid[i] = up_valid[i] & ~lane_kill[i].
   - A killed lane still loads its payload; only valid is dropped.
   - The stall state of downstream is irrelevant here; the stall controller never asserts s_up = 0 with s_dn = 1.
5. Hold (s_up = 1, s_dn = 1): all outputs keep their values.

Counters (evaluated every non-reset cycle, independent of flush):
- cnt_clr = 1 zeroes both counters. Clear has priority over increment in the same cycle.
- stall_cnt increments when s_up = 1.
- bubble_cnt increments when row 3 is taken, i.e. not when flush masks it.
- Both counters saturate at 2^CNT_W-1 and never wrap.

Flush behaviour:
- Flush overrides hold. A flushed register under a continuing stall stays empty until the next advance.

## Timing
- Latency: 1 cycle from up_* to dn_* on advance.
- No combinational path from any input to any output; all outputs come directly from flops.
- Reset values: dn_valid = 0, dn_data = {LANES{RESET_VAL}}, stall_cnt = 0, bubble_cnt = 0.
- Reset asserted mid-stall or mid-flush overrides everything on that edge. The first cycle after rst returns to 1 follows the normal priority.
- flush and advance asserted together: flush wins, and the upstream payload is discarded.
- The elaboration check also requires LANES in 1..4 and CNT_W ≥ 1.

## Test plan
- Reset: hold rst = 0 for 2 cycles with up_valid = 1 and up_data = 0xDEADBEEF -> dn_valid = 0, dn_data = RESET_VAL, both counters 0. Release rst, stall = 0 -> next cycle dn_data = 0xDEADBEEF, dn_valid = 1.
- Bubble vs hold (STAGE = 2): stall = 6'b000100 for 1 cycle -> dn_valid = 0, dn_data = 0 (CLEAR_ON_BUBBLE = 1), bubble_cnt = 1, stall_cnt = 1. Then stall = 6'b001100 for 3 cycles -> outputs frozen, stall_cnt = 4, bubble_cnt = 1.
- Flush priority: registered payload 0x12345678 valid, drive stall = 6'b001100 with flush = 1 -> dn_valid = 0, dn_data = 0, bubble_cnt unchanged. Release stall with up_data = 0xA5A5A5A5 -> dn_valid = 1, dn_data = 0xA5A5A5A5.
- Multi-lane kill (LANES = 2): up_valid = 2'b11, lane_kill = 2'b10, lane0 = 0x11, lane1 = 0x22, advance -> dn_valid = 2'b01, lane1 data = 0x22.
- Low-power bubble (CLEAR_ON_BUBBLE = 0): registered payload 0xCAFEF00D, stall = 6'b000100 -> dn_valid = 0, dn_data stays 0xCAFEF00D.
- Counter saturation (CNT_W = 4): hold s_up = 1 for 20 cycles -> stall_cnt stops at 15. Assert cnt_clr together with s_up = 1 -> stall_cnt = 0 on that edge and 1 on the following edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage pipeline register carrying LANES lanes of DATA_W-bit payload,
// each lane with its own valid bit. The register decodes its own slice of the
// global stall vector (s_up = stall[STAGE], s_dn = stall[STAGE+1]) to decide,
// on every rising edge, whether to advance, insert a bubble or hold. A flush
// empties the register regardless of stall. Two saturating performance
// counters track stalled cycles and inserted bubbles.
//
// Update priority on each rising clk edge (first match wins):
//   rst = 0          -> everything to reset values
//   flush = 1        -> all lanes invalid, payload = RESET_VAL
//   s_up & ~s_dn     -> bubble: invalid, payload cleared or held
//   ~s_up            -> advance: load upstream, killed lanes drop valid only
//   s_up & s_dn      -> hold
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-low reset
//   stall        in   [STALL_W-1:0]       global stall vector
//   flush        in   flush of this register
//   up_valid     in   [LANES-1:0]         per-lane valid from upstream
//   up_data      in   [LANES*DATA_W-1:0]  upstream payload, lane i at [i*DATA_W +: DATA_W]
//   lane_kill    in   [LANES-1:0]         per-lane squash applied on load
//   dn_valid     out  [LANES-1:0]         registered per-lane valid
//   dn_data      out  [LANES*DATA_W-1:0]  registered payload
//   cnt_clr      in   synchronous clear of both counters
//   stall_cnt    out  [CNT_W-1:0]         cycles with s_up = 1, saturating
//   bubble_cnt   out  [CNT_W-1:0]         bubbles inserted, saturating
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W          = 32,
    parameter int                 LANES           = 1,
    parameter int                 STALL_W         = 6,
    parameter int                 STAGE           = 2,
    parameter logic [DATA_W-1:0]  RESET_VAL       = '0,
    parameter bit                 CLEAR_ON_BUBBLE = 1'b1,
    parameter int                 CNT_W           = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES-1:0]          up_valid,
    input  logic [LANES*DATA_W-1:0]   up_data,
    input  logic [LANES-1:0]          lane_kill,
    output logic [LANES-1:0]          dn_valid,
    output logic [LANES*DATA_W-1:0]   dn_data,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
        $fatal(1, "pipe_stage_reg: STAGE+1 (%0d) must be < STALL_W (%0d)", STAGE + 1, STALL_W);
    end
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $fatal(1, "pipe_stage_reg: LANES (%0d) must be in 1..4", LANES);
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $fatal(1, "pipe_stage_reg: CNT_W (%0d) must be >= 1", CNT_W);
    end

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_BUBBLE,
        UPD_ADVANCE,
        UPD_HOLD
    } upd_e;

    localparam logic [LANES*DATA_W-1:0] DATA_RST = {LANES{RESET_VAL}};
    localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Stall decode and update selection
    // -------------------------------------------------------------------------
    logic s_up;
    logic s_dn;
    upd_e upd;

    assign s_up = stall[STAGE];
    assign s_dn = stall[STAGE+1];

    always_comb begin
        if (flush) begin
            upd = UPD_FLUSH;
        end else if (s_up && !s_dn) begin
            upd = UPD_BUBBLE;
        end else if (!s_up) begin
            // s_dn is ignored: the stall controller never freezes downstream
            // while this stage advances.
            upd = UPD_ADVANCE;
        end else begin
            upd = UPD_HOLD;
        end
    end

    // -------------------------------------------------------------------------
    // Payload / valid next state
    // -------------------------------------------------------------------------
    logic [LANES-1:0]        valid_d,  valid_q;
    logic [LANES*DATA_W-1:0] data_d,   data_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        unique case (upd)
            UPD_FLUSH: begin
                valid_d = '0;
                data_d  = DATA_RST;
            end
            UPD_BUBBLE: begin
                valid_d = '0;
                if (CLEAR_ON_BUBBLE) begin
                    data_d = DATA_RST;
                end
            end
            UPD_ADVANCE: begin
                // A killed lane still loads its payload; only valid drops.
                valid_d = up_valid & ~lane_kill;
                data_d  = up_data;
            end
            UPD_HOLD: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
            default: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Performance counters: clear beats increment, both saturate.
    // Counting ignores flush for stall_cnt; bubble_cnt only counts bubbles
    // that were actually inserted (flush masks them).
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_d,  stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (s_up && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if ((upd == UPD_BUBBLE) && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            data_q       <= DATA_RST;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Outputs come straight from flops: no input-to-output comb path.
    assign dn_valid   = valid_q;
    assign dn_data    = data_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances share stall / flush / rst / cnt_clr:
//   dut    : LANES=2, CNT_W=4,  CLEAR_ON_BUBBLE=1, RESET_VAL=0
//   dut_lp : LANES=1, CNT_W=16, CLEAR_ON_BUBBLE=0, RESET_VAL=0x0BADF00D
//            (lane 0 of the shared upstream inputs)
// A behavioural model applies the update rules lane by lane with plain
// integers and arrays; every edge both instances are compared against it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          DW    = 32;
    localparam int          LN    = 2;
    localparam int          CW    = 4;
    localparam int          LP_CW = 16;
    localparam logic [31:0] LP_RV = 32'h0BAD_F00D;
    localparam int          A_MAX = (1 << CW) - 1;
    localparam int          L_MAX = (1 << LP_CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic              cnt_clr;
    logic [LN-1:0]     up_valid;
    logic [LN-1:0]     lane_kill;
    logic [LN*DW-1:0]  up_data;

    logic [LN-1:0]     dn_valid;
    logic [LN*DW-1:0]  dn_data;
    logic [CW-1:0]     stall_cnt;
    logic [CW-1:0]     bubble_cnt;

    logic [0:0]        lp_dn_valid;
    logic [DW-1:0]     lp_dn_data;
    logic [LP_CW-1:0]  lp_stall_cnt;
    logic [LP_CW-1:0]  lp_bubble_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(DW), .LANES(LN), .STALL_W(6), .STAGE(2),
        .RESET_VAL(32'h0), .CLEAR_ON_BUBBLE(1'b1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .up_valid(up_valid), .up_data(up_data), .lane_kill(lane_kill),
        .dn_valid(dn_valid), .dn_data(dn_data), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(
        .DATA_W(DW), .LANES(1), .STALL_W(6), .STAGE(2),
        .RESET_VAL(LP_RV), .CLEAR_ON_BUBBLE(1'b0), .CNT_W(LP_CW)
    ) dut_lp (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .up_valid(up_valid[0:0]), .up_data(up_data[DW-1:0]), .lane_kill(lane_kill[0:0]),
        .dn_valid(lp_dn_valid), .dn_data(lp_dn_data), .cnt_clr(cnt_clr),
        .stall_cnt(lp_stall_cnt), .bubble_cnt(lp_bubble_cnt)
    );

    // ---------------- reference model ----------------
    bit          m_valid [LN];
    logic [31:0] m_data  [LN];
    int          m_sc, m_bc;
    bit          l_valid;
    logic [31:0] l_data;
    int          l_sc, l_bc;

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic model_edge();
        bit su, sd, bubble;
        su = stall[2];
        sd = stall[3];
        if (!rst) begin
            for (int i = 0; i < LN; i++) begin
                m_valid[i] = 0;
                m_data[i]  = 32'h0;
            end
            l_valid = 0; l_data = LP_RV;
            m_sc = 0; m_bc = 0; l_sc = 0; l_bc = 0;
        end else begin
            bubble = !flush && su && !sd;
            if (cnt_clr) begin
                m_sc = 0; m_bc = 0; l_sc = 0; l_bc = 0;
            end else begin
                if (su) begin
                    m_sc = sat_inc(m_sc, A_MAX);
                    l_sc = sat_inc(l_sc, L_MAX);
                end
                if (bubble) begin
                    m_bc = sat_inc(m_bc, A_MAX);
                    l_bc = sat_inc(l_bc, L_MAX);
                end
            end
            if (flush) begin
                for (int i = 0; i < LN; i++) begin
                    m_valid[i] = 0;
                    m_data[i]  = 32'h0;
                end
                l_valid = 0; l_data = LP_RV;
            end else if (bubble) begin
                for (int i = 0; i < LN; i++) begin
                    m_valid[i] = 0;
                    m_data[i]  = 32'h0;
                end
                l_valid = 0;             // low-power: payload kept
            end else if (!su) begin
                for (int i = 0; i < LN; i++) begin
                    m_valid[i] = up_valid[i] && !lane_kill[i];
                    m_data[i]  = up_data[i*DW +: DW];
                end
                l_valid = up_valid[0] && !lane_kill[0];
                l_data  = up_data[DW-1:0];
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check("dn_valid",      64'(dn_valid), 64'({m_valid[1], m_valid[0]}));
        check("dn_data",       64'(dn_data),  {m_data[1], m_data[0]});
        check("stall_cnt",     64'(stall_cnt),  64'(m_sc));
        check("bubble_cnt",    64'(bubble_cnt), 64'(m_bc));
        check("lp_dn_valid",   64'(lp_dn_valid), 64'(l_valid));
        check("lp_dn_data",    64'(lp_dn_data),  64'(l_data));
        check("lp_stall_cnt",  64'(lp_stall_cnt),  64'(l_sc));
        check("lp_bubble_cnt", 64'(lp_bubble_cnt), 64'(l_bc));
    endtask

    // One rising edge: update model, sample outputs 1 ns later, compare.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
        up_valid = 2'b11; lane_kill = 2'b00;
        up_data = {32'h0, 32'hDEAD_BEEF};

        // Reset held two cycles with live upstream traffic.
        cycle(); cycle();
        check("rst_valid", 64'(dn_valid), 64'h0);
        check("rst_data",  64'(dn_data),  64'h0);
        check("rst_scnt",  64'(stall_cnt), 64'h0);
        check("rst_lp_data", 64'(lp_dn_data), 64'(LP_RV));

        // Release and advance.
        rst = 1'b1;
        cycle();
        check("adv_data",  64'(dn_data[31:0]), 64'hDEAD_BEEF);
        check("adv_valid", 64'(dn_valid[0]), 64'h1);

        // Bubble then hold.
        stall = 6'b000100;
        cycle();
        check("bub_valid", 64'(dn_valid), 64'h0);
        check("bub_data",  64'(dn_data), 64'h0);
        check("bub_bcnt",  64'(bubble_cnt), 64'h1);
        check("bub_scnt",  64'(stall_cnt), 64'h1);
        stall = 6'b001100;
        repeat (3) cycle();
        check("hold_scnt", 64'(stall_cnt), 64'h4);
        check("hold_bcnt", 64'(bubble_cnt), 64'h1);

        // Flush over hold.
        stall = 6'b000000; up_valid = 2'b01; up_data = {32'h0, 32'h1234_5678};
        cycle();
        stall = 6'b001100; flush = 1'b1;
        cycle();
        check("fl_valid", 64'(dn_valid), 64'h0);
        check("fl_data",  64'(dn_data), 64'h0);
        check("fl_bcnt",  64'(bubble_cnt), 64'h1);
        stall = 6'b000000; flush = 1'b0; up_data = {32'h0, 32'hA5A5_A5A5};
        cycle();
        check("fl_rel_valid", 64'(dn_valid[0]), 64'h1);
        check("fl_rel_data",  64'(dn_data[31:0]), 64'hA5A5_A5A5);

        // Multi-lane kill.
        up_valid = 2'b11; lane_kill = 2'b10; up_data = {32'h22, 32'h11};
        cycle();
        check("kill_valid", 64'(dn_valid), 64'h1);
        check("kill_lane1", 64'(dn_data[63:32]), 64'h22);

        // Low-power bubble on dut_lp.
        lane_kill = 2'b00; up_valid = 2'b01; up_data = {32'h0, 32'hCAFE_F00D};
        cycle();
        stall = 6'b000100;
        cycle();
        check("lp_bub_valid", 64'(lp_dn_valid), 64'h0);
        check("lp_bub_data",  64'(lp_dn_data), 64'hCAFE_F00D);

        // Saturation, then clear with s_up still high.
        stall = 6'b001100;
        repeat (20) cycle();
        check("sat_scnt", 64'(stall_cnt), 64'hF);
        cnt_clr = 1'b1;
        cycle();
        check("clr_scnt", 64'(stall_cnt), 64'h0);
        cnt_clr = 1'b0;
        cycle();
        check("post_clr_scnt", 64'(stall_cnt), 64'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 59) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            stall     = 6'($urandom);
            stall[2]  = ($urandom_range(0, 9) < 6);
            stall[3]  = ($urandom_range(0, 1) == 0);
            up_valid  = 2'($urandom);
            lane_kill = 2'($urandom);
            up_data   = {$urandom, $urandom};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
